// File: rtl/jk_bank_sched.sv
// Round-robin scheduler sharing one external JK flip-flop bank between N_REQ requesters.
// Each accepted op drives j/k for one cycle, then the resulting bank state is returned.
module jk_bank_sched #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_mask,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       j_out,
  output logic [WIDTH-1:0]       k_out,
  input  logic [WIDTH-1:0]       q_in,
  output logic                   rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_q,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_q_q, rsp_q_d;

  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW:0]     cand;
  logic [1:0]       win_op;
  logic [WIDTH-1:0] win_mask;

  // First valid requester at or above rr_ptr, wrapping past N_REQ-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(N_REQ)) cand = cand - (IDW+1)'(N_REQ);
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found = 1'b1;
        win   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    win_op   = '0;
    win_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IDW'(i)) begin
        win_op   = req_op[2*i +: 2];
        win_mask = req_mask[WIDTH*i +: WIDTH];
      end
    end
  end

  // The winner's op/mask are captured directly as the j/k pattern for APPLY.
  always_comb begin
    state_d     = state_q;
    req_ready   = '0;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    j_d         = '0;
    k_d         = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_q_d     = rsp_q_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[win] = 1'b1;
          id_d           = win;
          rr_ptr_d       = (win == IDW'(N_REQ-1)) ? '0 : win + 1'b1;
          j_d            = win_mask & {WIDTH{win_op[1]}};
          k_d            = win_mask & {WIDTH{win_op[0]}};
          state_d        = APPLY;
        end
      end
      APPLY: state_d = CHECK;
      CHECK: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_q_d     = q_in;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      j_q         <= '0;
      k_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_q_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      j_q         <= j_d;
      k_q         <= k_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_q_q     <= rsp_q_d;
    end
  end

  assign j_out     = j_q;
  assign k_out     = k_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_q     = rsp_q_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_jk_bank_sched.sv
// Bench for jk_bank_sched: JK bank model, transaction-level reference scheduler,
// and a scoreboard monitor that checks every response as it appears.
module tb_jk_bank_sched;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [2*N-1:0] req_op = '0;
  logic [W*N-1:0] req_mask = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   j_out, k_out, q_in;
  logic           rsp_valid;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_q;
  logic           busy;

  always #5 clk = ~clk;

  jk_bank_sched #(.WIDTH(W), .N_REQ(N), .IDW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_mask(req_mask), .req_ready(req_ready), .j_out(j_out), .k_out(k_out),
    .q_in(q_in), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q), .busy(busy)
  );

  logic [W-1:0] bank;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bank <= '0;
    else        bank <= (j_out & ~bank) | (~k_out & bank);
  end
  assign q_in = bank;

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [W-1:0] q;
    int unsigned cyc;
  } exp_t;
  exp_t         sb[$];
  int           grant_log[$];
  logic [W-1:0] rsp_log[$];

  logic         pend[N];
  logic [1:0]   pop[N];
  logic [W-1:0] pmask[N];
  int           cnt = 0;
  int           rr = 0;
  logic [W-1:0] mbank = '0;
  logic [W-1:0] ej = '0;
  logic [W-1:0] ek = '0;
  bit           refill = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] apply_op(logic [W-1:0] b, logic [1:0] op, logic [W-1:0] m);
    case (op)
      2'b10:   return b | m;
      2'b01:   return b & ~m;
      2'b11:   return b ^ m;
      default: return b;
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = pend[i];
      req_op[2*i +: 2]   = pop[i];
      req_mask[W*i +: W] = pmask[i];
    end
  endtask

  task automatic clear_pend();
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; pop[i] = 2'b00; pmask[i] = '0;
    end
  endtask

  task automatic model_reset();
    sb.delete();
    cnt = 0; rr = 0; mbank = '0; ej = '0; ek = '0;
  endtask

  // One clock of stimulus plus the reference scheduler's view of that cycle.
  task automatic step();
    int w;
    int gi;
    logic [N-1:0] er;
    @(negedge clk);
    drive();
    #1;
    chk("busy", busy, cnt != 0);
    chk("j_out", j_out, (cnt == 2) ? ej : '0);
    chk("k_out", k_out, (cnt == 2) ? ek : '0);
    w = -1;
    if (cnt == 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (rr + k) % N;
        if (w < 0 && pend[c]) w = c;
      end
    end
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", req_ready, er);
    gi = -1;
    for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
    if (gi >= 0) grant_log.push_back(gi);
    if (w >= 0) begin
      mbank = apply_op(mbank, pop[w], pmask[w]);
      sb.push_back('{w, mbank, cyc_cnt + 3});
      ej = pmask[w] & {W{pop[w][1]}};
      ek = pmask[w] & {W{pop[w][0]}};
      rr = (w + 1) % N;
      pend[w] = 1'b0;
      cnt = 3;
    end
    if (cnt > 0) cnt--;
    if (refill) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          pend[i] = 1'b1; pop[i] = 2'($urandom_range(3)); pmask[i] = W'($urandom);
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_pend();
    drive();
    model_reset();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_j", j_out, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got id %0d q %0h with none outstanding", rsp_id, rsp_q);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_q", rsp_q, e.q);
          chk("rsp_cycle", cyc_cnt, e.cyc);
          rsp_log.push_back(rsp_q);
        end
      end else if (sb.size() > 0 && sb[0].cyc < cyc_cnt) begin
        checks++; errors++;
        $display("FAIL rsp_missing: got no response, required id %0d by cycle %0d", sb[0].id, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    int e3[6] = '{0, 1, 2, 3, 0, 1};
    int e4[3] = '{2, 0, 2};
    logic [W-1:0] e2[4] = '{8'hF0, 8'h0F, 8'h0C, 8'h0C};
    logic [1:0]   o2[4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [W-1:0] m2[4] = '{8'hF0, 8'hFF, 8'h03, 8'hFF};

    clear_pend();
    #1 rst_n = 1'b0;
    #1;
    chk("por_busy", busy, 0);
    chk("por_j", j_out, 0);
    chk("por_k", k_out, 0);
    chk("por_rsp_valid", rsp_valid, 0);
    chk("por_rsp_id", rsp_id, 0);
    chk("por_rsp_q", rsp_q, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of APPLY
    do_reset();
    pend[0] = 1'b1; pop[0] = 2'b10; pmask[0] = 8'hFF;
    step();
    @(posedge clk); #1;
    chk("t1_j_apply", j_out, 8'hFF);
    rst_n = 1'b0;
    #1;
    chk("t1_j_async", j_out, 0);
    chk("t1_k_async", k_out, 0);
    chk("t1_busy_async", busy, 0);
    chk("t1_rsp_valid_async", rsp_valid, 0);
    chk("t1_rsp_id_async", rsp_id, 0);
    chk("t1_rsp_q_async", rsp_q, 0);
    clear_pend();
    drive();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    grant_log.delete();
    pend[0] = 1'b1; pop[0] = 2'b10; pmask[0] = 8'h0F;
    run(4);
    chk("t1_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // Each op kind on a cleared bank
    do_reset();
    rsp_log.delete();
    for (int i = 0; i < 4; i++) begin
      pend[0] = 1'b1; pop[0] = o2[i]; pmask[0] = m2[i];
      run(3);
    end
    run(2);
    chk("t2_nrsp", rsp_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_q%0d", i), (i < rsp_log.size()) ? rsp_log[i] : 'x, e2[i]);

    // All requesters continuously valid, back-to-back accepts
    do_reset();
    grant_log.delete();
    refill = 1;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1; pop[i] = 2'($urandom_range(3)); pmask[i] = W'($urandom);
    end
    run(18);
    refill = 0;
    clear_pend();
    run(4);
    chk("t3_ngrant", grant_log.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t3_grant%0d", i), (i < grant_log.size()) ? grant_log[i] : -1, e3[i]);

    // Pointer at 3 with requesters 0 and 2 pending
    do_reset();
    grant_log.delete();
    pend[2] = 1'b1; pop[2] = 2'b11; pmask[2] = 8'h5A;
    run(3);
    pend[0] = 1'b1; pop[0] = 2'b10; pmask[0] = 8'h81;
    pend[2] = 1'b1; pop[2] = 2'b01; pmask[2] = 8'h18;
    run(7);
    chk("t4_ngrant", grant_log.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t4_grant%0d", i), (i < grant_log.size()) ? grant_log[i] : -1, e4[i]);

    // Quiet bus
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t6_rsp_valid", rsp_valid, 0);
    end

    // Random traffic with occasional drops
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1; pop[i] = 2'($urandom_range(3)); pmask[i] = W'($urandom);
        end else if (pend[i] && $urandom_range(15) == 0) begin
          pend[i] = 1'b0;
        end
      end
      step();
    end
    clear_pend();
    run(5);
    chk("drain_outstanding", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
